// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RV32I field-bundle to instruction-word encoder
// Legal bundles become 32-bit words behind one output register; illegal ones are counted.
module instr_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_last,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err,
  output logic [7:0]  err_count,
  output logic [15:0] enc_count,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] FMT_I = 3'b000;
  localparam logic [2:0] FMT_S = 3'b001;
  localparam logic [2:0] FMT_U = 3'b010;
  localparam logic [2:0] FMT_R = 3'b011;
  localparam logic [2:0] FMT_B = 3'b101;
  localparam logic [2:0] FMT_J = 3'b110;
  localparam logic [6:0] OP_IMM = 7'b0010011;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

  state_t      state_q, state_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [31:0] out_addr_q, out_addr_d;
  logic [31:0] addr_q, addr_d;
  logic        err_q, err_d;
  logic [7:0]  err_count_q, err_count_d;
  logic [15:0] enc_count_q, enc_count_d;

  logic        is_shift, fits12, fits13, fits21, legal;
  logic [31:0] word;
  logic        accept, out_hs;

  // Range checks: the immediate fits N signed bits when everything above bit N-1 is pure sign.
  always_comb begin
    is_shift = (in_opcode == OP_IMM) && ((in_funct3 == 3'b001) || (in_funct3 == 3'b101));
    fits12   = (&in_imm[31:11]) || !(|in_imm[31:11]);
    fits13   = (&in_imm[31:12]) || !(|in_imm[31:12]);
    fits21   = (&in_imm[31:20]) || !(|in_imm[31:20]);
    word     = '0;
    legal    = 1'b0;
    case (in_fmt)
      FMT_R: begin
        word  = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
        legal = 1'b1;
      end
      FMT_I: begin
        if (is_shift) begin
          word  = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
          legal = !(|in_imm[31:5]);
        end else begin
          word  = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
          legal = fits12;
        end
      end
      FMT_S: begin
        word  = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        legal = fits12;
      end
      FMT_B: begin
        word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3, in_imm[4:1], in_imm[11], in_opcode};
        legal = fits13 && !in_imm[0];
      end
      FMT_U: begin
        word  = {in_imm[31:12], in_rd, in_opcode};
        legal = !(|in_imm[11:0]);
      end
      FMT_J: begin
        word  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        legal = fits21 && !in_imm[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_addr_d  = out_addr_q;
    addr_d      = addr_q;
    err_d       = 1'b0;
    err_count_d = err_count_q;
    enc_count_d = enc_count_q;
    done        = 1'b0;
    in_ready    = (state_q == ST_RUN) && (!out_valid_q || out_ready);
    accept      = in_valid && in_ready;
    out_hs      = out_valid_q && out_ready;

    if (out_hs) begin
      out_valid_d = 1'b0;
      enc_count_d = enc_count_q + 16'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_RUN;
          addr_d      = base_addr;
          err_count_d = '0;
          enc_count_d = '0;
        end
      end
      ST_RUN: begin
        if (accept) begin
          if (legal) begin
            out_valid_d = 1'b1;
            out_instr_d = word;
            out_addr_d  = addr_q;
            addr_d      = addr_q + 32'd4;
          end else begin
            err_d = 1'b1;
            if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
          end
          if (in_last) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!out_valid_q) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_addr_q  <= '0;
      addr_q      <= '0;
      err_q       <= 1'b0;
      err_count_q <= '0;
      enc_count_q <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_addr_q  <= out_addr_d;
      addr_q      <= addr_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
      enc_count_q <= enc_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_addr  = out_addr_q;
  assign err       = err_q;
  assign err_count = err_count_q;
  assign enc_count = enc_count_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have one clock and one reset; reset is synchronous and active-low.
REQ-002 SHALL expose, in order:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  pulse: latch base_addr, enter RUN
- base_addr  in  32  first byte address written
- in_valid  in  1  field bundle valid
- in_ready  out  1  bundle accepted when in_valid&in_ready
- in_last  in  1  marks final bundle of program
- in_fmt  in  3  000 I, 001 S, 010 U, 011 R, 101 B, 110 J; 100/111 illegal
- in_opcode  in  7  opcode[6:0]
- in_funct3  in  3  funct3
- in_funct7  in  7  funct7
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_imm  in  32  signed immediate (U: full 32-bit value)
- out_valid  out  1  encoded word valid
- out_ready  in  1  sink accepts when out_valid&out_ready
- out_instr  out  32  encoded RV32I word
- out_addr  out  32  byte address of out_instr
- err  out  1  one-cycle pulse: bundle rejected
- err_count  out  8  rejected bundles, saturating
- enc_count  out  16  words emitted, wrapping
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at program end

Function
REQ-003 FSM states IDLE, RUN, DRAIN; IDLE->RUN on start; RUN->DRAIN when a bundle with in_last=1 is accepted; DRAIN->IDLE when out stage empty, asserting done that cycle.
REQ-004 start in RUN/DRAIN SHALL be ignored.
REQ-005 in_ready SHALL be 0 in IDLE and DRAIN; in RUN in_ready = !out_valid | out_ready.
REQ-006 Latency: accepted legal bundle SHALL appear on out_instr with out_valid=1 the next cycle (single register stage).
REQ-007 While out_valid=1 & out_ready=0, out_instr, out_addr, out_valid SHALL hold stable.
REQ-008 Encoding: R {f7,rs2,rs1,f3,rd,op}; I {imm[11:0],rs1,f3,rd,op}; S {imm[11:5],rs2,rs1,f3,imm[4:0],op}; B {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}; U {imm[31:12],rd,op}; J {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
REQ-009 I-format with opcode 0010011 and f3 001/101 SHALL use {f7,imm[4:0]} as bits[31:20]; imm[4:0] must satisfy 0..31.
REQ-010 Legality: I/S imm in [-2048,2047]; B imm in [-4096,4094], even; J imm in [-1048576,1048574], even; U imm[11:0]=0; shift imm in 0..31; fmt 100/111 illegal.
REQ-011 Accepted illegal bundle SHALL: not set out_valid, pulse err next cycle, increment err_count (saturate 255), not advance address; in_last on an illegal bundle still moves to DRAIN.
REQ-012 Address counter SHALL load base_addr on start and add 4 per accepted legal bundle, wrapping mod 2^32; out_addr is the address of that word.
REQ-013 enc_count SHALL increment on each out handshake, wrapping at 65535->0; cleared on start.
REQ-014 err_count cleared on start.
REQ-015 Accept and emit in same cycle SHALL be supported with no bubble.

Reset
REQ-016 rst_n=0 at a clock edge SHALL force: state IDLE, out_valid 0, out_instr 0, out_addr 0, err 0, done 0, busy 0, err_count 0, enc_count 0, in_ready 0, address counter 0.
REQ-017 Reset mid-RUN/DRAIN SHALL discard any held word without a handshake.

Verification
REQ-018 start base=0x1000; R add x3,x1,x2 (op 0110011) -> next cycle out_instr 0x002081B3, out_addr 0x1000.
REQ-019 Back-to-back, out_ready=1: I addi x1,x0,5 -> 0x00500093 @0x1000; S sw x2,8(x1) -> 0x0020A423 @0x1004; B beq x0,x0,-4 -> 0xFE000EE3 @0x1008; J jal x1,2048 with in_last -> 0x001000EF @0x100C, then done pulse, busy 0, enc_count 4.
REQ-020 I imm=2048 -> err pulse, err_count 1, no out_valid, next legal word still at prior address; B imm=3 -> err.
REQ-021 out_ready=0 for 5 cycles with word held -> out_instr stable, in_ready 0, no bundle lost; release -> words emitted in order.
REQ-022 rst_n low 1 cycle during RUN with out_valid=1 -> all outputs per REQ-016 next cycle; in_ready 0 until new start.
